block_memory: RTL and testbench

BLOCK_MEMORY -- requirements
Module: block_memory

---
 rtl/block_memory.sv | 71 +++++++
 tb/tb_block_memory.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_memory.sv
// block_memory: fixed-latency block-transfer memory with read abort.
// Ports: Clk/Rst (async, active-high) | Address, ReadMiss, WriteReq, Write_data, abort (request side)
//        Read_data, ReadReady, WriteDone, Busy (completion side). Word i of a block sits at bits [32i+31:32i].
module block_memory #(
  parameter int WORDS = 512,
  parameter int BLOCK_WORDS = 4,
  parameter int LATENCY = 20
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [31:0]              Address,
  input  logic                     ReadMiss,
  input  logic                     WriteReq,
  input  logic [32*BLOCK_WORDS-1:0] Write_data,
  input  logic                     abort,
  output logic [32*BLOCK_WORDS-1:0] Read_data,
  output logic                     ReadReady,
  output logic                     WriteDone,
  output logic                     Busy
);
  localparam int AW = $clog2(WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [2:0] {IDLE, READING, WRITING, READ_READY, WRITE_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [AW-1:0] base;
  logic [32*BLOCK_WORDS-1:0] wbuf, rd_blk;
  logic [31:0] mem [WORDS];
  logic last, rd_xfer, wr_xfer;
  assign Busy = state != IDLE;
  always_comb begin
    state_n = state;
    rd_blk = '0;
    last = cnt == CW'(LATENCY - 1);
    // abort outranks the transfer on the final read edge
    rd_xfer = state == READING && !abort && last;
    wr_xfer = state == WRITING && last;
    case (state)
      IDLE:    state_n = WriteReq ? WRITING : ReadMiss ? READING : IDLE;
      READING: state_n = abort ? IDLE : last ? READ_READY : READING;
      WRITING: state_n = last ? WRITE_DONE : WRITING;
      default: state_n = IDLE;
    endcase
    for (int i = 0; i < BLOCK_WORDS; i++) rd_blk[32*i +: 32] = mem[base + AW'(i)];
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt <= '0;
      Read_data <= '0;
      ReadReady <= 1'b0;
      WriteDone <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state_n == READING || state_n == WRITING) ? cnt + 1'b1 : '0;
      ReadReady <= rd_xfer;
      WriteDone <= wr_xfer;
      if (rd_xfer) Read_data <= rd_blk;
    end
  end
  // Request capture and storage are never reset; an operation killed by Rst
  // never reaches its transfer edge, so memory stays untouched.
  always_ff @(posedge Clk) begin
    if (state == IDLE) begin
      base <= Address[AW+1:2] & ~AW'(BLOCK_WORDS - 1);
      wbuf <= Write_data;
    end
    if (wr_xfer)
      for (int i = 0; i < BLOCK_WORDS; i++) mem[base + AW'(i)] <= wbuf[32*i +: 32];
  end
endmodule

// File: tb/tb_block_memory.sv
// tb_block_memory: randomized self-checking bench for block_memory against an array model.
module tb_block_memory;
  localparam int LAT = 20;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic [31:0] Address = '0;
  logic ReadMiss = 1'b0, WriteReq = 1'b0, abort = 1'b0;
  logic [127:0] Write_data = '0, Read_data;
  logic ReadReady, WriteDone, Busy;
  int passed = 0, total = 0;
  logic [31:0] model [512];
  int written[$];

  block_memory #(.WORDS(512), .BLOCK_WORDS(4), .LATENCY(LAT)) dut (
    .Clk(Clk), .Rst(Rst), .Address(Address), .ReadMiss(ReadMiss), .WriteReq(WriteReq),
    .Write_data(Write_data), .abort(abort), .Read_data(Read_data), .ReadReady(ReadReady),
    .WriteDone(WriteDone), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  function automatic int blk(input logic [31:0] a);
    return int'(((a >> 2) & 32'hFFFF_FFFC) % 512);
  endfunction

  function automatic void mwrite(input logic [31:0] a, input logic [127:0] d);
    for (int i = 0; i < 4; i++) model[(blk(a) + i) % 512] = d[32*i +: 32];
  endfunction

  function automatic logic [127:0] mread(input logic [31:0] a);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = model[(blk(a) + i) % 512];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start(input logic rd, input logic wr, input logic [31:0] a, input logic [127:0] d);
    @(negedge Clk);
    Address = a; ReadMiss = rd; WriteReq = wr; Write_data = d;
    @(posedge Clk); #1;
    ReadMiss = 0; WriteReq = 0;
  endtask

  task automatic wait_done(input bit rd, input int from, output int e);
    e = from;
    while (e < 200) begin
      @(posedge Clk); #1;
      e++;
      if (rd ? ReadReady : WriteDone) return;
    end
  endtask

  task automatic do_op(input bit rd, input logic [31:0] a, input logic [127:0] d, output int e, output logic [2:0] after);
    start(rd, !rd, a, d);
    wait_done(rd, 1, e);
    @(posedge Clk); #1;
    after = {ReadReady, WriteDone, Busy};
  endtask

  task automatic test_reset();
    #2 Rst = 1;
    #1;
    total++; if (Busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Busy); else passed++;
    total++; if (ReadReady !== 1'b0) $display("FAIL reset_readready: got %b expected 0", ReadReady); else passed++;
    total++; if (WriteDone !== 1'b0) $display("FAIL reset_writedone: got %b expected 0", WriteDone); else passed++;
    total++; if (Read_data !== '0) $display("FAIL reset_read_data: got %h expected 0", Read_data); else passed++;
    repeat (2) @(negedge Clk);
    Rst = 0;
  endtask

  task automatic test_basic();
    int e;
    logic [2:0] after;
    logic [127:0] exp = {32'hD, 32'hC, 32'hB, 32'hA};
    do_op(0, 32'h40, exp, e, after);
    mwrite(32'h40, exp);
    total++; if (e !== LAT) $display("FAIL basic_write_latency: got %0d expected %0d", e, LAT); else passed++;
    total++; if (after !== 3'b000) $display("FAIL basic_write_pulse_end: got %b expected 000", after); else passed++;
    do_op(1, 32'h48, '0, e, after);
    total++; if (e !== LAT) $display("FAIL basic_read_latency: got %0d expected %0d", e, LAT); else passed++;
    total++; if (after !== 3'b000) $display("FAIL basic_read_pulse_end: got %b expected 000", after); else passed++;
    total++; if (Read_data !== exp) $display("FAIL basic_read_data: got %h expected %h", Read_data, exp); else passed++;
    @(posedge Clk); #1;
    total++; if (Read_data !== exp) $display("FAIL basic_read_hold: got %h expected %h", Read_data, exp); else passed++;
  endtask

  task automatic test_simultaneous();
    int e;
    logic [127:0] d = rnd128();
    @(negedge Clk);
    Address = 32'h100; ReadMiss = 1; WriteReq = 1; Write_data = d;
    @(posedge Clk); #1;
    WriteReq = 0;
    wait_done(0, 1, e);
    mwrite(32'h100, d);
    total++; if (e !== LAT) $display("FAIL simul_write_latency: got %0d expected %0d", e, LAT); else passed++;
    total++; if (ReadReady !== 1'b0) $display("FAIL simul_no_early_read: got %b expected 0", ReadReady); else passed++;
    @(posedge Clk); #1;
    total++; if (Busy !== 1'b0) $display("FAIL simul_idle_after_write: got %b expected 0", Busy); else passed++;
    @(posedge Clk); #1;
    total++; if (Busy !== 1'b1) $display("FAIL simul_read_accepted: got %b expected 1", Busy); else passed++;
    ReadMiss = 0;
    wait_done(1, 1, e);
    total++; if (e !== LAT) $display("FAIL simul_read_latency: got %0d expected %0d", e, LAT); else passed++;
    total++; if (Read_data !== mread(32'h100)) $display("FAIL simul_read_data: got %h expected %h", Read_data, mread(32'h100)); else passed++;
    @(posedge Clk); #1;
  endtask

  task automatic test_abort();
    int e;
    bit seen = 0;
    logic [127:0] prev = Read_data;
    start(1, 0, 32'h40, '0);
    repeat (8) @(posedge Clk);
    @(negedge Clk); abort = 1;
    @(posedge Clk); #1; abort = 0;
    total++; if (Busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", Busy); else passed++;
    repeat (25) begin @(posedge Clk); #1; if (ReadReady) seen = 1; end
    total++; if (seen !== 1'b0) $display("FAIL abort_no_readready: got %b expected 0", seen); else passed++;
    total++; if (Read_data !== prev) $display("FAIL abort_data_kept: got %h expected %h", Read_data, prev); else passed++;
    start(1, 0, 32'h100, '0);
    repeat (18) @(posedge Clk);
    @(negedge Clk); abort = 1;
    @(posedge Clk); #1; abort = 0;
    total++; if ({ReadReady, Busy} !== 2'b00) $display("FAIL abort_last_edge: got %b expected 00", {ReadReady, Busy}); else passed++;
    @(posedge Clk); #1;
    total++; if (ReadReady !== 1'b0) $display("FAIL abort_last_no_pulse: got %b expected 0", ReadReady); else passed++;
    total++; if (Read_data !== prev) $display("FAIL abort_last_data_kept: got %h expected %h", Read_data, prev); else passed++;
    start(1, 0, 32'h40, '0);
    wait_done(1, 1, e);
    total++; if (e !== LAT) $display("FAIL abort_reread_latency: got %0d expected %0d", e, LAT); else passed++;
    total++; if (Read_data !== mread(32'h40)) $display("FAIL abort_reread_data: got %h expected %h", Read_data, mread(32'h40)); else passed++;
    @(posedge Clk); #1;
  endtask

  task automatic test_write_abort();
    int e;
    logic [2:0] after;
    logic [127:0] d = rnd128();
    start(0, 1, 32'h200, d);
    repeat (3) @(posedge Clk);
    @(negedge Clk); abort = 1;
    @(posedge Clk); #1; abort = 0;
    total++; if (Busy !== 1'b1) $display("FAIL wabort_still_busy: got %b expected 1", Busy); else passed++;
    wait_done(0, 5, e);
    mwrite(32'h200, d);
    total++; if (e !== LAT) $display("FAIL wabort_latency: got %0d expected %0d", e, LAT); else passed++;
    @(posedge Clk); #1;
    do_op(1, 32'h204, '0, e, after);
    total++; if (Read_data !== mread(32'h204)) $display("FAIL wabort_data: got %h expected %h", Read_data, mread(32'h204)); else passed++;
  endtask

  task automatic test_reset_mid();
    int e;
    bit seen = 0;
    logic [2:0] after;
    logic [127:0] d0 = rnd128();
    do_op(0, 32'h0, d0, e, after);
    mwrite(32'h0, d0);
    start(1, 0, 32'h40, '0);
    repeat (11) @(posedge Clk);
    #3 Rst = 1;
    #1;
    total++; if ({Busy, ReadReady, WriteDone} !== 3'b000) $display("FAIL rstmid_flags: got %b expected 000", {Busy, ReadReady, WriteDone}); else passed++;
    total++; if (Read_data !== '0) $display("FAIL rstmid_read_data: got %h expected 0", Read_data); else passed++;
    #1 Rst = 0;
    repeat (25) begin @(posedge Clk); #1; if (ReadReady) seen = 1; end
    total++; if (seen !== 1'b0) $display("FAIL rstmid_no_readready: got %b expected 0", seen); else passed++;
    start(0, 1, 32'h40, rnd128());
    repeat (8) @(posedge Clk);
    #3 Rst = 1;
    #2 Rst = 0;
    seen = 0;
    repeat (25) begin @(posedge Clk); #1; if (WriteDone) seen = 1; end
    total++; if (seen !== 1'b0) $display("FAIL rstmid_no_writedone: got %b expected 0", seen); else passed++;
    do_op(1, 32'h40, '0, e, after);
    total++; if (Read_data !== mread(32'h40)) $display("FAIL rstmid_mem_kept: got %h expected %h", Read_data, mread(32'h40)); else passed++;
    do_op(1, 32'h800, '0, e, after);
    total++; if (e !== LAT) $display("FAIL rstmid_wrap_latency: got %0d expected %0d", e, LAT); else passed++;
    total++; if (Read_data !== mread(32'h800)) $display("FAIL rstmid_wrap_data: got %h expected %h", Read_data, mread(32'h800)); else passed++;
  endtask

  task automatic test_random();
    int e, b;
    logic [2:0] after;
    logic [31:0] a;
    logic [127:0] d;
    for (int n = 0; n < 40; n++) begin
      if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
        a = $urandom;
        d = rnd128();
        do_op(0, a, d, e, after);
        mwrite(a, d);
        written.push_back(blk(a));
        total++; if (e !== LAT) $display("FAIL rand_write_latency: got %0d expected %0d", e, LAT); else passed++;
      end else begin
        b = written[$urandom_range(0, written.size() - 1)];
        a = ($urandom & 32'hFFFF_F800) | (32'(b) << 2) | 32'($urandom_range(0, 15));
        do_op(1, a, '0, e, after);
        total++; if (e !== LAT) $display("FAIL rand_read_latency: got %0d expected %0d", e, LAT); else passed++;
        total++; if (Read_data !== mread(a)) $display("FAIL rand_read_data addr %h: got %h expected %h", a, Read_data, mread(a)); else passed++;
      end
      total++; if (after !== 3'b000) $display("FAIL rand_pulse_end: got %b expected 000", after); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_abort();
    test_write_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
